// File: rtl/fifo_cdc_pkg.sv
// Shared async-FIFO pointer helpers.
// Gray/binary conversions sized for any pointer up to MAX_W bits.
package fifo_cdc_pkg;

  localparam int PTR_EXTRA = 1;
  localparam int MAX_W     = 32;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs decode exactly.
  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary decoder.
// Shared by the read- and write-side pointer controllers.
module fifo_gray2bin
  import fifo_cdc_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic [MAX_W-1:0] wide;

  assign wide = gray2bin(MAX_W'(gray));
  assign bin  = wide[W-1:0];

endmodule

// File: rtl/fifo_rptr_level_ctrl.sv
// Read-side pointer and status controller of the async FIFO.
// Produces read address, Gray pointer, level, empty/aempty, underflow.
module fifo_rptr_level_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter bit AEMPTY_RST = 1'b1
) (
  input  logic                          R_CLK,
  input  logic                          R_rst_n,
  input  logic                          R_inc,
  input  logic [ADDR_WIDTH+PTR_EXTRA-1:0] Rq2_wptr,
  input  logic [ADDR_WIDTH+PTR_EXTRA-1:0] R_aempty_thresh,
  input  logic                          R_underflow_clr,
  output logic [ADDR_WIDTH+PTR_EXTRA-1:0] R_ptr,
  output logic [ADDR_WIDTH-1:0]         R_Addr,
  output logic                          R_empty,
  output logic                          R_aempty,
  output logic [ADDR_WIDTH+PTR_EXTRA-1:0] R_level,
  output logic                          R_underflow
);

  localparam int PW = ADDR_WIDTH + PTR_EXTRA;

  logic [PW-1:0]    bin;
  logic [PW-1:0]    bin_next;
  logic [PW-1:0]    gray_next;
  logic [PW-1:0]    wbin;
  logic [PW-1:0]    level_next;
  logic [MAX_W-1:0] gray_wide;
  logic             rd_en;
  logic             uf_set;

  assign rd_en    = R_inc & ~R_empty;
  assign uf_set   = R_inc & R_empty;
  assign bin_next = bin + PW'(rd_en);

  assign gray_wide = bin2gray(MAX_W'(bin_next));
  assign gray_next = gray_wide[PW-1:0];

  fifo_gray2bin #(
    .W (PW)
  ) u_wdec (
    .gray (Rq2_wptr),
    .bin  (wbin)
  );

  // Modular difference keeps the level right across pointer wrap.
  assign level_next = wbin - bin_next;

  assign R_Addr = bin[ADDR_WIDTH-1:0];

  always_ff @(posedge R_CLK or negedge R_rst_n) begin
    if (!R_rst_n) begin
      bin         <= '0;
      R_ptr       <= '0;
      R_empty     <= 1'b1;
      R_aempty    <= AEMPTY_RST;
      R_level     <= '0;
      R_underflow <= 1'b0;
    end else begin
      bin      <= bin_next;
      R_ptr    <= gray_next;
      R_empty  <= (gray_next == Rq2_wptr);
      R_level  <= level_next;
      R_aempty <= (level_next <= R_aempty_thresh);
      if (uf_set)
        R_underflow <= 1'b1;
      else if (R_underflow_clr)
        R_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rptr_level_ctrl.sv
// Self-checking bench for fifo_rptr_level_ctrl (ADDR_WIDTH=4).
// Word-count model plus directed literal checks and random traffic.
module tb_fifo_rptr_level_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic          R_CLK = 1'b0;
  logic          R_rst_n = 1'b0;
  logic          R_inc = 1'b0;
  logic [PW-1:0] Rq2_wptr = '0;
  logic [PW-1:0] R_aempty_thresh = '0;
  logic          R_underflow_clr = 1'b0;
  logic [PW-1:0] R_ptr;
  logic [AW-1:0] R_Addr;
  logic          R_empty;
  logic          R_aempty;
  logic [PW-1:0] R_level;
  logic          R_underflow;

  fifo_rptr_level_ctrl #(
    .ADDR_WIDTH (AW),
    .AEMPTY_RST (1'b1)
  ) dut (
    .R_CLK           (R_CLK),
    .R_rst_n         (R_rst_n),
    .R_inc           (R_inc),
    .Rq2_wptr        (Rq2_wptr),
    .R_aempty_thresh (R_aempty_thresh),
    .R_underflow_clr (R_underflow_clr),
    .R_ptr           (R_ptr),
    .R_Addr          (R_Addr),
    .R_empty         (R_empty),
    .R_aempty        (R_aempty),
    .R_level         (R_level),
    .R_underflow     (R_underflow)
  );

  always #5 R_CLK = ~R_CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: total words read/written as plain integers.
  int m_rd  = 0;
  int m_wr  = 0;
  int m_lvl = 0;
  bit m_emp = 1'b1;
  bit m_ae  = 1'b1;
  bit m_uf  = 1'b0;

  function automatic logic [PW-1:0] gray_of(input int v);
    int b;
    b = v % PMOD;
    return PW'(b ^ (b / 2));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge R_CLK or negedge R_rst_n) begin
    if (!R_rst_n) begin
      m_rd  = 0;
      m_wr  = 0;
      m_lvl = 0;
      m_emp = 1'b1;
      m_ae  = 1'b1;
      m_uf  = 1'b0;
    end else begin
      if (R_inc && m_emp)
        m_uf = 1'b1;
      else if (R_underflow_clr)
        m_uf = 1'b0;
      if (R_inc && !m_emp)
        m_rd++;
      m_lvl = ((m_wr - m_rd) % PMOD + PMOD) % PMOD;
      m_emp = (m_lvl == 0);
      m_ae  = (m_lvl <= int'(R_aempty_thresh));
    end
  end

  always @(negedge R_CLK) begin
    chk("addr",      int'(R_Addr),      m_rd % DEPTH);
    chk("ptr",       int'(R_ptr),       int'(gray_of(m_rd)));
    chk("level",     int'(R_level),     m_lvl);
    chk("empty",     int'(R_empty),     int'(m_emp));
    chk("aempty",    int'(R_aempty),    int'(m_ae));
    chk("underflow", int'(R_underflow), int'(m_uf));
  end

  task automatic tick();
    @(negedge R_CLK);
  endtask

  task automatic set_wr(input int w);
    m_wr     = w;
    Rq2_wptr = gray_of(w);
  endtask

  task automatic reset_pulse();
    R_inc           = 1'b0;
    R_underflow_clr = 1'b0;
    R_rst_n         = 1'b0;
    set_wr(0);
    tick();
    R_rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ptr"},   int'(R_ptr),       0);
    chk({tag, "_addr"},  int'(R_Addr),      0);
    chk({tag, "_empty"}, int'(R_empty),     1);
    chk({tag, "_level"}, int'(R_level),     0);
    chk({tag, "_ae"},    int'(R_aempty),    1);
    chk({tag, "_uf"},    int'(R_underflow), 0);
  endtask

  initial begin
    int guard;
    int step;
    int cap;
    int tsel;
    logic [PW-1:0] tlist [5];
    tlist[0] = 5'd0;  tlist[1] = 5'd2;  tlist[2] = 5'd7;
    tlist[3] = 5'd16; tlist[4] = 5'd31;

    // Reset values
    tick();
    tick();
    chk_reset_vals("rst");
    R_rst_n = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    // Fill level and draining five words
    R_aempty_thresh = 5'd2;
    set_wr(5);
    tick();
    chk("fill_level", int'(R_level), 5);
    chk("fill_empty", int'(R_empty), 0);
    R_inc = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("drain_addr",  int'(R_Addr),  k);
      chk("drain_level", int'(R_level), 5 - k);
    end
    chk("drain_empty", int'(R_empty), 1);
    R_inc = 1'b0;

    // Almost-empty
    reset_pulse();
    R_aempty_thresh = 5'd2;
    set_wr(4);
    tick();
    chk("ae_lvl4", int'(R_aempty), 0);
    R_inc = 1'b1;
    tick();
    tick();
    R_inc = 1'b0;
    chk("ae_lvl2_level", int'(R_level),  2);
    chk("ae_lvl2_ae",    int'(R_aempty), 1);
    chk("ae_lvl2_empty", int'(R_empty),  0);

    // Wrap: stream 30 words, then 5 more across the pointer wrap
    reset_pulse();
    guard = 0;
    R_inc = 1'b1;
    while (m_rd < 30 && guard < 200) begin
      set_wr((m_rd + 4 > 30) ? 30 : m_rd + 4);
      tick();
      guard++;
    end
    chk("wrap_preload", m_rd, 30);
    R_inc = 1'b0;
    set_wr(35);
    tick();
    chk("wrap_level", int'(R_level), 5);
    chk("wrap_addr0", int'(R_Addr), 14);
    chk("wrap_msb30", int'(R_ptr[PW-1]), 1);
    R_inc = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("wrap_addr", int'(R_Addr), (14 + k) % 16);
    end
    R_inc = 1'b0;
    chk("wrap_ptr",   int'(R_ptr),   2);
    chk("wrap_empty", int'(R_empty), 1);

    // Underflow: set, set beats clear, then clear
    reset_pulse();
    R_inc = 1'b1;
    tick();
    chk("uf_set",  int'(R_underflow), 1);
    chk("uf_addr", int'(R_Addr),      0);
    R_underflow_clr = 1'b1;
    tick();
    chk("uf_set_wins", int'(R_underflow), 1);
    R_inc = 1'b0;
    tick();
    chk("uf_clear", int'(R_underflow), 0);
    R_underflow_clr = 1'b0;

    // Full FIFO, then asynchronous reset during a read
    R_aempty_thresh = 5'd2;
    set_wr(16);
    tick();
    chk("full_level", int'(R_level),  16);
    chk("full_empty", int'(R_empty),  0);
    chk("full_ae",    int'(R_aempty), 0);
    R_inc = 1'b1;
    @(posedge R_CLK);
    #2;
    R_rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    R_inc = 1'b0;
    set_wr(0);
    tick();
    R_rst_n = 1'b1;
    tick();

    // Random traffic with assorted thresholds
    tsel = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin
        R_aempty_thresh = tlist[tsel % 5];
        tsel++;
      end
      cap  = m_rd + DEPTH - m_wr;
      step = (cap <= 0) ? 0 : $urandom_range(0, (cap < 3) ? cap : 3);
      set_wr(m_wr + step);
      R_inc           = ($urandom % 4) != 0;
      R_underflow_clr = ($urandom % 8) == 0;
      tick();
    end
    R_inc           = 1'b0;
    R_underflow_clr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
